mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage of the five-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register (`pipe4`). It performs word loads and stores over a simple request/acknowledge data-memory bus, stalls the front of the pipeline while an access is outstanding, and presents registered results to `pipe4`. Non-memory instructions pass through with one cycle of latency.

## Interface
- `TIMEOUT_CYCLES`, default 16: number of WAIT-state cycles before an access is aborted. Used only with `MEM_TIMEOUT_EN`.
- `CLK`  in  1: clock; all state changes on the rising edge.
- `RST`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: the EX/MEM slot holds a real instruction.
- `MemRead`, `MemWrite`  in  1 each: load or store request. Never both high.
- `ALU_result`  in  32: byte address for a memory op; result value otherwise.
- `Wdata`  in  32: store data.
- `Wreg_addr`  in  5, `RegWrite`  in  1, `MemToReg`  in  1, `Branch`  in  1: sideband control, carried to the output.
- `Stall`  out  1: combinational; upstream holds all inputs stable while high.
- `mem_req`  out  1, `mem_we`  out  1, `mem_addr`  out  32, `mem_wdata`  out  32: data-memory bus, registered.
- `mem_rdata`  in  32, `mem_ack`  in  1: memory response; `mem_rdata` is valid in the `mem_ack` cycle.
- `outMemRdata`  out  32, `outALU_result`  out  32, `outWreg_addr`  out  5, `outRegWrite`  out  1, `outMemToReg`  out  1, `outBranch`  out  1: registered results to `pipe4`.
- `out_valid`  out  1: the output registers hold a retired instruction.
- `misaligned_err`  out  1: one-cycle pulse.
- `bus_err`  out  1: one-cycle pulse.

## Operation
- FSM states: IDLE and WAIT.
- `start` = IDLE & `in_valid` & (`MemRead` | `MemWrite`) & (`ALU_result[1:0]` == 0).
- **IDLE, `in_valid`, no memory op:**
  - Next edge loads `outALU_result` and the sideband fields, sets `outMemRdata` = 0 and `out_valid` = 1.
- **IDLE, `start`:**
  - Next edge: `mem_req` ← 1, `mem_we` ← `MemWrite`, `mem_addr` ← `ALU_result`, `mem_wdata` ← `Wdata`.
  - The sideband fields are latched internally; state → WAIT; `out_valid` ← 0.
- **IDLE, memory op with `ALU_result[1:0]` ≠ 0:**
  - No bus transaction is issued.
  - Next edge loads the outputs with `outRegWrite` forced to 0, `outMemRdata` = 0, `out_valid` = 1, and pulses `misaligned_err`.
- **WAIT:**
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are held stable.
  - On the edge sampling `mem_ack` = 1: state → IDLE, `mem_req` ← 0, and the outputs load from the latched sideband.
  - `outMemRdata` ← `mem_rdata` for a load, 0 for a store; `out_valid` ← 1.
- **Idle slots:** `in_valid` = 0 in IDLE → `out_valid` ← 0 at the next edge; the other output registers hold their values.
- **Stall** = `start` | (WAIT & !`mem_ack`).
  - Stall is low in the ack cycle, so upstream advances on the same edge that retires the access.
  - The instruction presented in that ack cycle is not processed until the FSM is back in IDLE. Upstream therefore receives Stall for it in the following cycle, which gives one bubble per memory op.
- `mem_ack` is ignored outside WAIT.

## Timing
- **Reset** (at the edge with `RST` = 1): state IDLE, timeout counter 0, and every output register 0. This covers `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, all `out*` ports, `out_valid`, `misaligned_err` and `bus_err`.
- **Reset mid-WAIT:** `mem_req` falls at the reset edge; no output is produced for the aborted access. A late `mem_ack` after reset is ignored.
- **Non-memory latency:** 1 edge.
- **Memory latency:** the request is issued at edge E0. If `mem_ack` is sampled high at edge E0+k (k ≥ 1), the result is visible after E0+k.
- **Back-to-back memory ops:** the next `mem_req` rises no earlier than one edge after the previous `mem_req` falls.
- `misaligned_err` and `bus_err` are high for exactly one cycle each.

## Configuration
- **`MEM_TIMEOUT_EN` defined:**
  - A counter increments on each WAIT cycle without `mem_ack`.
  - When it reaches `TIMEOUT_CYCLES`: `mem_req` ← 0, state → IDLE, the outputs load with `outRegWrite` = 0, `outMemRdata` = 0, `out_valid` = 1, `bus_err` pulses, and the counter clears.
  - If `mem_ack` arrives in the same cycle the count is reached, `mem_ack` wins and the access completes normally.
- **`MEM_TIMEOUT_EN` undefined:** WAIT persists until `mem_ack`; `bus_err` is tied to 0 but the port remains.

## Test plan
- **Reset:** assert `RST` for 2 cycles with random inputs → all outputs 0, `Stall` = 0 after release.
- **ALU pass-through:** `in_valid` = 1, no memory op, `ALU_result` = 0x0000_1234, `Wreg_addr` = 5, `RegWrite` = 1 → one edge later `outALU_result` = 0x1234, `outWreg_addr` = 5, `out_valid` = 1, no `mem_req`.
- **Load with ack delay 3:** `MemRead` at 0x100, memory returns 0xDEAD_BEEF → `mem_req` high for 3 cycles with `mem_addr` = 0x100, `Stall` high until the ack cycle, `outMemRdata` = 0xDEADBEEF and `out_valid` = 1 after the ack edge.
- **Store:** `MemWrite` at 0x20, `Wdata` = 0x55, ack delay 1 → `mem_we` = 1, `mem_wdata` = 0x55, `outMemRdata` = 0.
- **Misaligned load:** `MemRead` at 0x102 → no `mem_req`, `misaligned_err` pulses once, `outRegWrite` = 0, `out_valid` = 1.
- **Timeout and reset mid-WAIT:**
  - With `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, no ack → `bus_err` pulses and `mem_req` falls after 4 WAIT cycles.
  - Assert `RST` in WAIT → `mem_req` = 0 next edge, and a subsequent `mem_ack` produces no `out_valid`.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Request/acknowledge data-memory bus between the memory-access stage (master) and data memory (slave).
interface mem_access_stage_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
   modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: word loads/stores over a req/ack bus, stalls upstream while busy.
// Optional access timeout with bus_err is enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                in_valid,
   input  logic                MemRead,
   input  logic                MemWrite,
   input  logic [31:0]         ALU_result,
   input  logic [31:0]         Wdata,
   input  logic [4:0]          Wreg_addr,
   input  logic                RegWrite,
   input  logic                MemToReg,
   input  logic                Branch,
   output logic                Stall,
   mem_access_stage_if.master  bus,
   output logic [31:0]         outMemRdata,
   output logic [31:0]         outALU_result,
   output logic [4:0]          outWreg_addr,
   output logic                outRegWrite,
   output logic                outMemToReg,
   output logic                outBranch,
   output logic                out_valid,
   output logic                misaligned_err,
   output logic                bus_err
);

`ifdef MEM_TIMEOUT_EN
   localparam bit TimeoutEn = 1'b1;
`else
   localparam bit TimeoutEn = 1'b0;
`endif
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic [4:0]  lat_wreg_addr_q, lat_wreg_addr_d;
   logic        lat_reg_write_q, lat_reg_write_d;
   logic        lat_mem_to_reg_q, lat_mem_to_reg_d;
   logic        lat_branch_q, lat_branch_d;
   logic [31:0] out_mem_rdata_q, out_mem_rdata_d, out_alu_result_q, out_alu_result_d;
   logic [4:0]  out_wreg_addr_q, out_wreg_addr_d;
   logic        out_reg_write_q, out_reg_write_d;
   logic        out_mem_to_reg_q, out_mem_to_reg_d;
   logic        out_branch_q, out_branch_d;
   logic        out_valid_q, out_valid_d;
   logic        misaligned_err_q, misaligned_err_d;
   logic        bus_err_q, bus_err_d;
   logic        is_mem_op, aligned, start;

   always_comb begin
      is_mem_op = MemRead | MemWrite;
      aligned   = (ALU_result[1:0] == 2'b00);
      start     = (state_q == ST_IDLE) & in_valid & is_mem_op & aligned;
      Stall     = start | ((state_q == ST_WAIT) & ~bus.mem_ack);
   end

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      cnt_inc          = cnt_q + CNT_W'(1);
      mem_req_d        = mem_req_q;
      mem_we_d         = mem_we_q;
      mem_addr_d       = mem_addr_q;
      mem_wdata_d      = mem_wdata_q;
      lat_wreg_addr_d  = lat_wreg_addr_q;
      lat_reg_write_d  = lat_reg_write_q;
      lat_mem_to_reg_d = lat_mem_to_reg_q;
      lat_branch_d     = lat_branch_q;
      out_mem_rdata_d  = out_mem_rdata_q;
      out_alu_result_d = out_alu_result_q;
      out_wreg_addr_d  = out_wreg_addr_q;
      out_reg_write_d  = out_reg_write_q;
      out_mem_to_reg_d = out_mem_to_reg_q;
      out_branch_d     = out_branch_q;
      out_valid_d      = out_valid_q;
      misaligned_err_d = 1'b0;
      bus_err_d        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!in_valid) begin
               out_valid_d = 1'b0;
            end else if (start) begin
               state_d          = ST_WAIT;
               mem_req_d        = 1'b1;
               mem_we_d         = MemWrite;
               mem_addr_d       = ALU_result;
               mem_wdata_d      = Wdata;
               lat_wreg_addr_d  = Wreg_addr;
               lat_reg_write_d  = RegWrite;
               lat_mem_to_reg_d = MemToReg;
               lat_branch_d     = Branch;
               out_valid_d      = 1'b0;
            end else begin
               // Non-memory ops retire directly; misaligned memory ops retire without writeback.
               out_alu_result_d = ALU_result;
               out_wreg_addr_d  = Wreg_addr;
               out_reg_write_d  = RegWrite & ~is_mem_op;
               out_mem_to_reg_d = MemToReg;
               out_branch_d     = Branch;
               out_mem_rdata_d  = 32'd0;
               out_valid_d      = 1'b1;
               misaligned_err_d = is_mem_op;
            end
         end
         ST_WAIT: begin
            if (bus.mem_ack) begin
               state_d          = ST_IDLE;
               cnt_d            = '0;
               mem_req_d        = 1'b0;
               out_alu_result_d = mem_addr_q;
               out_wreg_addr_d  = lat_wreg_addr_q;
               out_reg_write_d  = lat_reg_write_q;
               out_mem_to_reg_d = lat_mem_to_reg_q;
               out_branch_d     = lat_branch_q;
               out_mem_rdata_d  = mem_we_q ? 32'd0 : bus.mem_rdata;
               out_valid_d      = 1'b1;
            end else if (TimeoutEn && (cnt_inc == CNT_W'(TIMEOUT_CYCLES))) begin
               // Abandon the access; the instruction retires as a no-writeback bubble.
               state_d          = ST_IDLE;
               cnt_d            = '0;
               mem_req_d        = 1'b0;
               out_alu_result_d = mem_addr_q;
               out_wreg_addr_d  = lat_wreg_addr_q;
               out_reg_write_d  = 1'b0;
               out_mem_to_reg_d = lat_mem_to_reg_q;
               out_branch_d     = lat_branch_q;
               out_mem_rdata_d  = 32'd0;
               out_valid_d      = 1'b1;
               bus_err_d        = 1'b1;
            end else if (TimeoutEn) begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q          <= ST_IDLE;
         cnt_q            <= '0;
         mem_req_q        <= 1'b0;
         mem_we_q         <= 1'b0;
         mem_addr_q       <= 32'd0;
         mem_wdata_q      <= 32'd0;
         lat_wreg_addr_q  <= 5'd0;
         lat_reg_write_q  <= 1'b0;
         lat_mem_to_reg_q <= 1'b0;
         lat_branch_q     <= 1'b0;
         out_mem_rdata_q  <= 32'd0;
         out_alu_result_q <= 32'd0;
         out_wreg_addr_q  <= 5'd0;
         out_reg_write_q  <= 1'b0;
         out_mem_to_reg_q <= 1'b0;
         out_branch_q     <= 1'b0;
         out_valid_q      <= 1'b0;
         misaligned_err_q <= 1'b0;
         bus_err_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         mem_req_q        <= mem_req_d;
         mem_we_q         <= mem_we_d;
         mem_addr_q       <= mem_addr_d;
         mem_wdata_q      <= mem_wdata_d;
         lat_wreg_addr_q  <= lat_wreg_addr_d;
         lat_reg_write_q  <= lat_reg_write_d;
         lat_mem_to_reg_q <= lat_mem_to_reg_d;
         lat_branch_q     <= lat_branch_d;
         out_mem_rdata_q  <= out_mem_rdata_d;
         out_alu_result_q <= out_alu_result_d;
         out_wreg_addr_q  <= out_wreg_addr_d;
         out_reg_write_q  <= out_reg_write_d;
         out_mem_to_reg_q <= out_mem_to_reg_d;
         out_branch_q     <= out_branch_d;
         out_valid_q      <= out_valid_d;
         misaligned_err_q <= misaligned_err_d;
         bus_err_q        <= bus_err_d;
      end
   end

   assign bus.mem_req     = mem_req_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign outMemRdata     = out_mem_rdata_q;
   assign outALU_result   = out_alu_result_q;
   assign outWreg_addr    = out_wreg_addr_q;
   assign outRegWrite     = out_reg_write_q;
   assign outMemToReg     = out_mem_to_reg_q;
   assign outBranch       = out_branch_q;
   assign out_valid       = out_valid_q;
   assign misaligned_err  = misaligned_err_q;
   assign bus_err         = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed ops, a retirement-level reference model
// and a per-cycle compare process against that model.
`timescale 1ns/1ps
module tb_mem_access_stage;
   localparam int TimeoutCycles = 4;

   logic        clk, rst;
   logic        inValid, memRead, memWrite, regWrite, memToReg, branch;
   logic [31:0] aluResult, wdata;
   logic [4:0]  wregAddr;
   logic        stall;
   logic [31:0] outMemRdata, outAluResult;
   logic [4:0]  outWregAddr;
   logic        outRegWrite, outMemToReg, outBranch, outValid, misalignedErr, busErr;

   mem_access_stage_if memBus();

   mem_access_stage #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
      .CLK(clk), .RST(rst), .in_valid(inValid), .MemRead(memRead), .MemWrite(memWrite),
      .ALU_result(aluResult), .Wdata(wdata), .Wreg_addr(wregAddr), .RegWrite(regWrite),
      .MemToReg(memToReg), .Branch(branch), .Stall(stall), .bus(memBus),
      .outMemRdata(outMemRdata), .outALU_result(outAluResult), .outWreg_addr(outWregAddr),
      .outRegWrite(outRegWrite), .outMemToReg(outMemToReg), .outBranch(outBranch),
      .out_valid(outValid), .misaligned_err(misalignedErr), .bus_err(busErr)
   );

   typedef struct packed {
      logic [31:0] rdata;
      logic [31:0] alu;
      logic [4:0]  wreg;
      logic        rw;
      logic        m2r;
      logic        br;
      logic        mis;
      logic        berr;
   } ret_t;

   ret_t        expQ[$];
   ret_t        lastRet, cmpRet;
   int          checks = 0, errors = 0;
   bit          checkEn = 0;
   bit          txnActive = 0;
   logic [31:0] txnAddr, txnWdata, respData;
   logic        txnWe;
   int          reqCycles = 0, ackDelaySel = 0;
   bit          lateAckReq = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Retirement record derived purely from the architectural rules of the stage.
   function automatic ret_t predict(input logic rd, input logic wr, input logic [31:0] alu,
                                    input logic [4:0] wreg, input logic rw, input logic m2r,
                                    input logic br, input logic [31:0] memData, input bit timedOut);
      ret_t r;
      r = '0;
      r.alu  = alu;
      r.wreg = wreg;
      r.m2r  = m2r;
      r.br   = br;
      if (!(rd || wr)) begin
         r.rw = rw;
      end else if (alu % 4 != 0) begin
         r.mis = 1'b1;
      end else if (timedOut) begin
         r.berr = 1'b1;
      end else begin
         r.rw    = rw;
         r.rdata = rd ? memData : 32'd0;
      end
      return r;
   endfunction

   // Memory responder: acks once the request has been visible for ackDelaySel cycles.
   initial begin
      memBus.mem_ack   = 1'b0;
      memBus.mem_rdata = 32'h0BAD_F00D;
      forever begin
         @(posedge clk);
         #1;
         memBus.mem_ack   = 1'b0;
         memBus.mem_rdata = 32'h0BAD_F00D;
         if (lateAckReq) begin
            memBus.mem_ack   = 1'b1;
            memBus.mem_rdata = 32'hBAD0_BAD0;
            lateAckReq       = 0;
         end else if (memBus.mem_req === 1'b1) begin
            reqCycles++;
            if (reqCycles == ackDelaySel) begin
               memBus.mem_ack   = 1'b1;
               memBus.mem_rdata = respData;
            end
         end
      end
   end

   // Compare process: every cycle, outputs either retire the next expected record or hold the last.
   initial begin
      forever begin
         @(negedge clk);
         if (checkEn) begin
            if (outValid === 1'b1) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_retire", outValid, 32'd0);
               end else begin
                  cmpRet = expQ.pop_front();
                  checkOutput("ret_rdata", outMemRdata, cmpRet.rdata);
                  checkOutput("ret_alu", outAluResult, cmpRet.alu);
                  checkOutput("ret_wreg", outWregAddr, cmpRet.wreg);
                  checkOutput("ret_regwrite", outRegWrite, cmpRet.rw);
                  checkOutput("ret_memtoreg", outMemToReg, cmpRet.m2r);
                  checkOutput("ret_branch", outBranch, cmpRet.br);
                  checkOutput("ret_misaligned", misalignedErr, cmpRet.mis);
                  checkOutput("ret_bus_err", busErr, cmpRet.berr);
                  lastRet = cmpRet;
               end
            end else begin
               checkOutput("hold_valid", outValid, 32'd0);
               checkOutput("hold_rdata", outMemRdata, lastRet.rdata);
               checkOutput("hold_alu", outAluResult, lastRet.alu);
               checkOutput("hold_wreg", outWregAddr, lastRet.wreg);
               checkOutput("hold_regwrite", outRegWrite, lastRet.rw);
               checkOutput("quiet_misaligned", misalignedErr, 32'd0);
               checkOutput("quiet_bus_err", busErr, 32'd0);
            end
            if (txnActive && memBus.mem_req === 1'b1) begin
               checkOutput("bus_addr", memBus.mem_addr, txnAddr);
               checkOutput("bus_we", memBus.mem_we, txnWe);
               checkOutput("bus_wdata", memBus.mem_wdata, txnWdata);
            end else if (!txnActive) begin
               checkOutput("bus_req_idle", memBus.mem_req, 32'd0);
            end
         end
      end
   end

   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] alu,
                                input logic [31:0] wd, input logic [4:0] wreg, input logic rw,
                                input logic m2r, input logic br, input logic [31:0] memData,
                                input int ackDelay, input bit expectTimeout);
      bit isBusOp;
      bit stalled;
      bit done;
      int stallCycles;
      int budget;
      isBusOp     = (rd || wr) && (alu % 4 == 0);
      inValid     = 1'b1;
      memRead     = rd;
      memWrite    = wr;
      aluResult   = alu;
      wdata       = wd;
      wregAddr    = wreg;
      regWrite    = rw;
      memToReg    = m2r;
      branch      = br;
      respData    = memData;
      ackDelaySel = ackDelay;
      reqCycles   = 0;
      if (isBusOp) begin
         txnAddr   = alu;
         txnWe     = wr;
         txnWdata  = wd;
         txnActive = 1;
      end
      expQ.push_back(predict(rd, wr, alu, wreg, rw, m2r, br, memData, expectTimeout));
      stallCycles = 0;
      budget      = 0;
      done        = 0;
      while (!done) begin
         @(negedge clk);
         stalled = stall;
         if (stalled) stallCycles++;
         @(posedge clk);
         #1;
         budget++;
         if (!stalled) done = 1;
         else if (expectTimeout && outValid === 1'b1) done = 1;
         else if (budget > 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_budget: waited %0d cycles, expected acceptance within 100", budget);
            done = 1;
         end
      end
      inValid   = 1'b0;
      txnActive = 0;
      if (!isBusOp) begin
         checkOutput("stall_cycles", stallCycles, 32'd0);
         checkOutput("req_cycles", reqCycles, 32'd0);
      end else if (expectTimeout) begin
         checkOutput("stall_cycles_timeout", stallCycles, TimeoutCycles + 1);
         checkOutput("req_cycles_timeout", reqCycles, TimeoutCycles);
      end else begin
         checkOutput("stall_cycles", stallCycles, ackDelay);
         checkOutput("req_cycles", reqCycles, ackDelay);
      end
   endtask

   task automatic idleCycles(input int n);
      inValid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic flushModel();
      expQ.delete();
      lastRet   = '0;
      txnActive = 0;
   endtask

   initial begin
      rst = 1'b1; inValid = 1'b0; memRead = 1'b0; memWrite = 1'b0; aluResult = '0; wdata = '0;
      wregAddr = '0; regWrite = 1'b0; memToReg = 1'b0; branch = 1'b0; lastRet = '0;
      txnAddr = '0; txnWdata = '0; txnWe = 1'b0; respData = '0;

      // Reset for two cycles with random inputs.
      @(posedge clk);
      #1;
      inValid   = 1'($urandom_range(0, 1));
      memRead   = 1'($urandom_range(0, 1));
      memWrite  = ~memRead;
      aluResult = $urandom();
      wdata     = $urandom();
      wregAddr  = 5'($urandom());
      regWrite  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; inValid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
      checkOutput("rst_mem_req", memBus.mem_req, 32'd0);
      checkOutput("rst_mem_we", memBus.mem_we, 32'd0);
      checkOutput("rst_mem_addr", memBus.mem_addr, 32'd0);
      checkOutput("rst_mem_wdata", memBus.mem_wdata, 32'd0);
      checkOutput("rst_out_rdata", outMemRdata, 32'd0);
      checkOutput("rst_out_alu", outAluResult, 32'd0);
      checkOutput("rst_out_wreg", outWregAddr, 32'd0);
      checkOutput("rst_out_regwrite", outRegWrite, 32'd0);
      checkOutput("rst_out_memtoreg", outMemToReg, 32'd0);
      checkOutput("rst_out_branch", outBranch, 32'd0);
      checkOutput("rst_out_valid", outValid, 32'd0);
      checkOutput("rst_misaligned", misalignedErr, 32'd0);
      checkOutput("rst_bus_err", busErr, 32'd0);
      checkOutput("rst_stall", stall, 32'd0);
      flushModel();
      checkEn = 1;

      $display("[TB] ALU pass-through");
      applyStimulus(1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0);
      checkOutput("lit_pass_alu", outAluResult, 32'h0000_1234);
      checkOutput("lit_pass_wreg", outWregAddr, 32'd5);
      checkOutput("lit_pass_valid", outValid, 32'd1);
      checkOutput("lit_pass_regwrite", outRegWrite, 32'd1);
      idleCycles(2);

      $display("[TB] load with ack delay 3");
      applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 3, 0);
      checkOutput("lit_load_rdata", outMemRdata, 32'hDEAD_BEEF);
      checkOutput("lit_load_valid", outValid, 32'd1);
      checkOutput("lit_load_req_low", memBus.mem_req, 32'd0);

      $display("[TB] store with ack delay 1");
      applyStimulus(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0055, 5'd3, 1'b0, 1'b0, 1'b0, 32'h7777_7777, 1, 0);
      checkOutput("lit_store_rdata", outMemRdata, 32'd0);
      checkOutput("lit_store_we", memBus.mem_we, 32'd1);
      checkOutput("lit_store_wdata", memBus.mem_wdata, 32'h0000_0055);

      $display("[TB] misaligned load");
      applyStimulus(1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 32'h0, 0, 0);
      checkOutput("lit_mis_err", misalignedErr, 32'd1);
      checkOutput("lit_mis_regwrite", outRegWrite, 32'd0);
      checkOutput("lit_mis_valid", outValid, 32'd1);
      idleCycles(1);

      $display("[TB] branch pass-through and back-to-back loads");
      applyStimulus(1'b0, 1'b0, 32'hCAFE_0000, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0, 0, 0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 32'h1111_2222, 2, 0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0204, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 32'h3333_4444, 1, 0);
      applyStimulus(1'b0, 1'b1, 32'h0000_0031, 32'hABCD_0123, 5'd12, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0);
      idleCycles(2);

`ifdef MEM_TIMEOUT_EN
      $display("[TB] access timeout");
      applyStimulus(1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0, 32'h0, -1, 1);
      checkOutput("lit_timeout_bus_err", busErr, 32'd1);
      checkOutput("lit_timeout_req", memBus.mem_req, 32'd0);
      checkOutput("lit_timeout_regwrite", outRegWrite, 32'd0);
      idleCycles(2);
`endif

      $display("[TB] reset while waiting for ack");
      inValid = 1'b1; memRead = 1'b1; memWrite = 1'b0; aluResult = 32'h0000_0400;
      wregAddr = 5'd14; regWrite = 1'b1; ackDelaySel = -1; reqCycles = 0;
      txnAddr = 32'h0000_0400; txnWe = 1'b0; txnWdata = wdata; txnActive = 1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checkOutput("wait_req_high", memBus.mem_req, 32'd1);
      checkEn = 0;
      rst     = 1'b1;
      inValid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("midrst_req", memBus.mem_req, 32'd0);
      checkOutput("midrst_valid", outValid, 32'd0);
      checkOutput("midrst_stall", stall, 32'd0);
      flushModel();
      checkEn    = 1;
      lateAckReq = 1;
      repeat (4) begin
         @(negedge clk);
         checkOutput("late_ack_no_retire", outValid, 32'd0);
      end
      @(posedge clk);
      #1;

      $display("[TB] recovery after reset");
      applyStimulus(1'b0, 1'b0, 32'h0000_5678, 32'h0, 5'd21, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0);
      checkOutput("lit_recover_alu", outAluResult, 32'h0000_5678);
      idleCycles(3);

      checkOutput("exp_queue_empty", expQ.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
